// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access pipeline stage sitting between the EX/MEM and MEM/WB registers.
// One instruction at a time is captured while the stage is idle. Non-memory
// instructions and misaligned memory instructions are answered the following
// cycle. Aligned loads and stores open a request on a variable-latency data
// port and hold upstream (stall) until the port acknowledges or a timeout
// counter gives up on the access. Load data is lane-selected and extended
// before it is registered toward write-back.
//
// Parameters
//   DATA_W   data/address width; the byte-lane logic assumes 4 lanes (32 bits)
//   TIMEOUT  number of request cycles without mem_ack before abort (1..255)
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-low reset
//   valid_in            upstream instruction valid (held while stall=1)
//   alu_result          effective address for mem ops, else write-back value
//   store_data          right-aligned store value
//   mem_read/mem_write  load / store (both set counts as a load)
//   mem_size            00 byte, 01 half, 10/11 word
//   mem_unsigned        1 zero-extends loads, 0 sign-extends
//   reg_write/dest_reg  register write intent and destination
//   stall               high while a memory access is outstanding
//   mem_req/we/addr/    data-port request; all fields stable while mem_req=1,
//   wdata/be            address word-aligned, store data replicated to lanes
//   mem_rdata/mem_ack   data-port response, ack only looked at during a request
//   valid_out           one-cycle pulse per finished instruction
//   wb_data/wb_dest     write-back value and destination register
//   wb_reg_write        register write for write-back (never for stores/errors)
//   misaligned          pulse with valid_out for a misaligned half/word access
//   bus_error           pulse with valid_out for a timed-out access
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic              reg_write,
  input  logic [4:0]        dest_reg,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              valid_out,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_dest,
  output logic              wb_reg_write,
  output logic              misaligned,
  output logic              bus_error
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REQ    = 1'b1;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  // Counter value of the last request cycle we are willing to wait through.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // Everything about the outstanding access, frozen at capture time so the
  // port fields stay stable for the whole request.
  typedef struct packed {
    logic [DATA_W-1:0] addr;   // word-aligned address driven on the port
    logic [1:0]        off;    // byte offset inside the word, for load lanes
    logic              we;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        size;
    logic              uns;
    logic              rw;     // register write of a load (0 for stores)
    logic [4:0]        dest;
  } req_t;

  logic [0:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;

  logic              valid_out_q, valid_out_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [4:0]        wb_dest_q, wb_dest_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              misaligned_q, misaligned_d;
  logic              bus_error_q, bus_error_d;

  // ---------------------------------------------------------------------------
  // Decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic              in_is_mem;
  logic              in_is_store;
  logic              in_misaligned;
  logic [3:0]        in_be;
  logic [DATA_W-1:0] in_wdata;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case statements can infer a latch.
    in_is_mem     = mem_read | mem_write;
    in_is_store   = mem_write & ~mem_read;   // read+write resolves to a load
    in_misaligned = 1'b0;
    in_be         = 4'b1111;
    in_wdata      = store_data;
    case (mem_size)
      SZ_BYTE: begin
        in_be    = 4'b0001 << alu_result[1:0];
        in_wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        in_misaligned = alu_result[0];
        in_be         = 4'b0011 << {alu_result[1], 1'b0};
        in_wdata      = {2{store_data[15:0]}};
      end
      default: begin
        // Word (size 11 behaves as a word as well).
        in_misaligned = |alu_result[1:0];
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load alignment: pick the addressed lane and extend it
  // ---------------------------------------------------------------------------
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;

  always_comb begin
    ld_byte = mem_rdata[{req_q.off, 3'b000} +: 8];
    ld_half = mem_rdata[{req_q.off[1], 4'b0000} +: 16];
    case (req_q.size)
      SZ_BYTE: ld_data = {{(DATA_W-8){ld_byte[7] & ~req_q.uns}}, ld_byte};
      SZ_HALF: ld_data = {{(DATA_W-16){ld_half[15] & ~req_q.uns}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_d          = req_q;
    valid_out_d    = 1'b0;           // result flags are single-cycle pulses
    wb_data_d      = wb_data_q;
    wb_dest_d      = wb_dest_q;
    wb_reg_write_d = 1'b0;
    misaligned_d   = 1'b0;
    bus_error_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (!in_is_mem) begin
            // Plain ALU instruction: pass straight through in one cycle.
            valid_out_d    = 1'b1;
            wb_data_d      = alu_result;
            wb_dest_d      = dest_reg;
            wb_reg_write_d = reg_write;
          end else if (in_misaligned) begin
            // Rejected without touching the port; no register write.
            valid_out_d  = 1'b1;
            misaligned_d = 1'b1;
            wb_data_d    = alu_result;
            wb_dest_d    = dest_reg;
          end else begin
            state_d    = S_REQ;
            cnt_d      = 8'd0;
            req_d.addr = {alu_result[DATA_W-1:2], 2'b00};
            req_d.off  = alu_result[1:0];
            req_d.we   = in_is_store;
            req_d.be   = in_be;
            req_d.wdata = in_wdata;
            req_d.size = mem_size;
            req_d.uns  = mem_unsigned;
            req_d.rw   = reg_write & ~in_is_store;
            req_d.dest = dest_reg;
          end
        end
      end

      S_REQ: begin
        if (mem_ack) begin
          // An ack always wins, including in the final timeout cycle.
          state_d        = S_IDLE;
          valid_out_d    = 1'b1;
          wb_dest_d      = req_q.dest;
          wb_reg_write_d = req_q.rw;
          if (!req_q.we) begin
            wb_data_d = ld_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          valid_out_d = 1'b1;
          bus_error_d = 1'b1;
          wb_dest_d   = req_q.dest;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop updates from the values
    // that existed before the edge, independent of statement order.
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      req_q          <= '0;
      valid_out_q    <= 1'b0;
      wb_data_q      <= '0;
      wb_dest_q      <= 5'd0;
      wb_reg_write_q <= 1'b0;
      misaligned_q   <= 1'b0;
      bus_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      valid_out_q    <= valid_out_d;
      wb_data_q      <= wb_data_d;
      wb_dest_q      <= wb_dest_d;
      wb_reg_write_q <= wb_reg_write_d;
      misaligned_q   <= misaligned_d;
      bus_error_q    <= bus_error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stall        = (state_q == S_REQ);
  assign mem_req      = (state_q == S_REQ);
  assign mem_we       = req_q.we;
  assign mem_addr     = req_q.addr;
  assign mem_wdata    = req_q.wdata;
  assign mem_be       = req_q.be;

  assign valid_out    = valid_out_q;
  assign wb_data      = wb_data_q;
  assign wb_dest      = wb_dest_q;
  assign wb_reg_write = wb_reg_write_q;
  assign misaligned   = misaligned_q;
  assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Bench for mem_stage with TIMEOUT=4. The bench plays both the upstream
// pipeline and the data memory. Expected results come from a hand-filled
// vector table and, for random traffic, from a reference model that works on
// access sizes and byte offsets arithmetically.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int TO    = 4;
  localparam int NEVER = 255;   // ack delay meaning "memory never answers"

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        reg_write;
  logic [4:0]  dest_reg;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        valid_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_reg_write;
  logic        misaligned;
  logic        bus_error;

  mem_stage #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .valid_in     (valid_in),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .reg_write    (reg_write),
    .dest_reg     (dest_reg),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .valid_out    (valid_out),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .wb_reg_write (wb_reg_write),
    .misaligned   (misaligned),
    .bus_error    (bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic        rw;
    logic [4:0]  dest;
  } instr_t;

  typedef struct {
    int          req;     // number of cycles mem_req is high
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
    logic        chk_wb;  // wb_data is defined for this outcome
    logic        wrw;
    logic        mis;
    logic        berr;
    logic [4:0]  dest;
  } exp_t;

  typedef struct {
    instr_t      i;
    int          ack_delay;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk_instr(input logic [31:0] alu, input logic [31:0] sd,
                                      input logic rd, input logic wr, input logic [1:0] size,
                                      input logic uns, input logic rw, input logic [4:0] dest);
    instr_t i;
    i.alu = alu; i.sd = sd; i.rd = rd; i.wr = wr;
    i.size = size; i.uns = uns; i.rw = rw; i.dest = dest;
    return i;
  endfunction

  function automatic exp_t mk_exp(input int req, input logic we, input logic [31:0] addr,
                                  input logic [3:0] be, input logic [31:0] wdata,
                                  input logic [31:0] wb, input logic chk_wb, input logic wrw,
                                  input logic mis, input logic berr, input logic [4:0] dest);
    exp_t e;
    e.req = req; e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
    e.wb = wb; e.chk_wb = chk_wb; e.wrw = wrw; e.mis = mis; e.berr = berr; e.dest = dest;
    return e;
  endfunction

  // Reference model: access size in bytes, offset in the word, and plain
  // arithmetic for lanes, replication and extension.
  function automatic exp_t model(input instr_t i, input int ack_delay, input logic [31:0] rdata);
    exp_t   e;
    int     n;
    int     off;
    longint v;
    longint span;
    n    = (i.size == 2'b00) ? 1 : (i.size == 2'b01) ? 2 : 4;
    off  = int'(i.alu % 32'd4);
    e = mk_exp(0, 1'b0, i.alu - 32'(off), 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, i.dest);
    if (!i.rd && !i.wr) begin
      e.wb = i.alu; e.wrw = i.rw; e.chk_wb = 1'b1;
    end else if ((off % n) != 0) begin
      e.mis = 1'b1;
    end else begin
      e.we = i.wr && !i.rd;
      e.be = 4'(((1 << n) - 1) << off);
      for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = i.sd[8*(k % n) +: 8];
      if (ack_delay >= TO) begin
        e.req = TO; e.berr = 1'b1;
      end else begin
        e.req = ack_delay + 1;
        if (!e.we) begin
          span = longint'(1) << (8 * n);
          v = longint'(rdata >> (8 * off)) % span;
          if (!i.uns && v >= span / 2) v = v - span;
          e.wb = v[31:0]; e.wrw = i.rw; e.chk_wb = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic drive(input instr_t i);
    alu_result = i.alu; store_data = i.sd; mem_read = i.rd; mem_write = i.wr;
    mem_size = i.size; mem_unsigned = i.uns; reg_write = i.rw; dest_reg = i.dest;
  endtask

  // Scramble the upstream fields so a stage that failed to latch shows it.
  task automatic scramble();
    alu_result = $urandom(); store_data = $urandom(); mem_read = 1'($urandom());
    mem_write = 1'($urandom()); mem_size = 2'($urandom()); mem_unsigned = 1'($urandom());
    reg_write = 1'($urandom()); dest_reg = 5'($urandom());
  endtask

  // Issue one instruction, act as the memory, and compare the outcome.
  task automatic run_instr(input instr_t i, input int ack_delay, input logic [31:0] rdata,
                           input exp_t e, input string tag);
    int          nreq;
    int          cyc;
    logic        done;
    logic        unstable;
    logic        we0;
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  b0;
    drive(i);
    valid_in = 1'b1;
    mem_ack  = 1'($urandom());      // ignored while idle
    @(posedge clock); #1;
    valid_in = 1'b0;
    mem_ack  = 1'b0;
    scramble();
    nreq = 0; cyc = 0; done = 1'b0; unstable = 1'b0;
    we0 = 1'b0; a0 = '0; w0 = '0; b0 = '0;
    while (!done && cyc < 40) begin
      if (valid_out) begin
        done = 1'b1;
      end else begin
        if (mem_req) begin
          if (nreq == 0) begin
            we0 = mem_we; a0 = mem_addr; w0 = mem_wdata; b0 = mem_be;
          end else if (mem_we !== we0 || mem_addr !== a0 || mem_wdata !== w0 || mem_be !== b0) begin
            unstable = 1'b1;
          end
          if (stall !== 1'b1) unstable = 1'b1;
          nreq++;
          mem_ack   = (nreq - 1 == ack_delay);
          mem_rdata = mem_ack ? rdata : $urandom();
        end
        @(posedge clock); #1;
        mem_ack = 1'b0;
        cyc++;
      end
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".nreq"}, nreq, e.req);
    check({tag, ".stable"}, 32'(unstable), 32'd0);
    if (e.req > 0) begin
      check({tag, ".addr"}, a0, e.addr);
      check({tag, ".we"}, 32'(we0), 32'(e.we));
      if (e.we) begin
        check({tag, ".be"}, 32'(b0), 32'(e.be));
        check({tag, ".wdata"}, w0, e.wdata);
      end
    end
    check({tag, ".flags"}, {29'd0, wb_reg_write, misaligned, bus_error}, {29'd0, e.wrw, e.mis, e.berr});
    check({tag, ".dest"}, 32'(wb_dest), 32'(e.dest));
    check({tag, ".stall"}, {30'd0, stall, mem_req}, 32'd0);
    if (e.chk_wb) check({tag, ".wb"}, wb_data, e.wb);
    @(posedge clock); #1;
    check({tag, ".pulse"}, {29'd0, valid_out, misaligned, bus_error}, 32'd0);
  endtask

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic   flag;
    instr_t ri;
    int     rd_delay;
    int     op;
    logic [31:0] rr;

    reset = 1'b0; valid_in = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    drive(mk_instr(32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0));
    repeat (2) @(posedge clock);
    #1;
    check("rst.ctl", {16'd0, stall, mem_req, mem_we, valid_out, wb_reg_write,
                      misaligned, bus_error, mem_be, wb_dest}, 32'd0);
    check("rst.addr", mem_addr, 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    check("rst.wb", wb_data, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // --- directed vector table (expected values worked out by hand) --------
    vecs[0]  = '{mk_instr(32'h0000_1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd5), 0, 32'h0,
                 mk_exp(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_1234, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5)};
    vecs[1]  = '{mk_instr(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd7), 3, 32'h80FF_0000,
                 mk_exp(4, 1'b0, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7)};
    vecs[2]  = '{mk_instr(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd7), 3, 32'h80FF_0000,
                 mk_exp(4, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0000_0080, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7)};
    vecs[3]  = '{mk_instr(32'h0000_0102, 32'hABCD_1234, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 5'd3), 0, 32'h0,
                 mk_exp(1, 1'b1, 32'h100, 4'b1100, 32'h1234_1234, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3)};
    vecs[4]  = '{mk_instr(32'h0000_0101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd9), 0, 32'h0,
                 mk_exp(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9)};
    vecs[5]  = '{mk_instr(32'h0000_0200, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd10), NEVER, 32'h0,
                 mk_exp(4, 1'b0, 32'h200, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10)};
    vecs[6]  = '{mk_instr(32'h0000_0200, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd10), 3, 32'hDEAD_BEEF,
                 mk_exp(4, 1'b0, 32'h200, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10)};
    vecs[7]  = '{mk_instr(32'h0000_0102, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd11), 1, 32'h8001_7FFF,
                 mk_exp(2, 1'b0, 32'h100, 4'h0, 32'h0, 32'hFFFF_8001, 1'b1, 1'b1, 1'b0, 1'b0, 5'd11)};
    vecs[8]  = '{mk_instr(32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 5'd12), 2, 32'h8001_F00F,
                 mk_exp(3, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0000_F00F, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12)};
    vecs[9]  = '{mk_instr(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd13), 0, 32'h0,
                 mk_exp(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd13)};
    vecs[10] = '{mk_instr(32'h0000_0101, 32'h0000_0055, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd14), 1, 32'h0,
                 mk_exp(2, 1'b1, 32'h100, 4'b0010, 32'h5555_5555, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd14)};
    vecs[11] = '{mk_instr(32'h0000_0104, 32'h1122_3344, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd15), 0, 32'h0,
                 mk_exp(1, 1'b1, 32'h104, 4'b1111, 32'h1122_3344, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15)};
    vecs[12] = '{mk_instr(32'h0000_0108, 32'h0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 5'd16), 2, 32'hCAFE_F00D,
                 mk_exp(3, 1'b0, 32'h108, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 1'b0, 5'd16)};
    vecs[13] = '{mk_instr(32'h0000_010A, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd17), 0, 32'h0,
                 mk_exp(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd17)};
    vecs[14] = '{mk_instr(32'h0000_0102, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd18), 0, 32'h00AB_0000,
                 mk_exp(1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0000_00AB, 1'b1, 1'b0, 1'b0, 1'b0, 5'd18)};
    vecs[15] = '{mk_instr(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0), 0, 32'h0,
                 mk_exp(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0)};

    for (int k = 0; k < 16; k++) begin
      run_instr(vecs[k].i, vecs[k].ack_delay, vecs[k].rdata, vecs[k].e, $sformatf("v%0d", k));
    end

    // --- reset in the middle of an access ---------------------------------
    drive(mk_instr(32'h0000_0300, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd20));
    valid_in = 1'b1;
    @(posedge clock); #1;
    valid_in = 1'b0;
    check("ra.req", 32'(mem_req), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("ra.drop", {29'd0, mem_req, stall, valid_out}, 32'd0);
    reset = 1'b1;
    mem_ack = 1'b1;
    flag = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      if (valid_out || mem_req) flag = 1'b1;
    end
    mem_ack = 1'b0;
    check("ra.quiet", 32'(flag), 32'd0);

    // --- back-to-back: instruction held during stall is taken right after --
    drive(mk_instr(32'h0000_0400, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd12));
    valid_in = 1'b1;
    @(posedge clock); #1;
    check("bb.req", {30'd0, mem_req, stall}, 32'd3);
    drive(mk_instr(32'h0000_0077, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd13));
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    check("bb.ld", wb_data, 32'h0BAD_CAFE);
    check("bb.ld_ctl", {24'd0, valid_out, stall, wb_reg_write, wb_dest}, {24'd0, 3'b101, 5'd12});
    @(posedge clock); #1;
    valid_in = 1'b0;
    check("bb.alu", wb_data, 32'h0000_0077);
    check("bb.alu_ctl", {24'd0, valid_out, mem_req, wb_reg_write, wb_dest}, {24'd0, 3'b101, 5'd13});
    @(posedge clock); #1;
    check("bb.end", 32'(valid_out), 32'd0);

    // --- randomized traffic against the reference model -------------------
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 3);
      ri.alu  = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFF);
      ri.sd   = $urandom();
      ri.rd   = (op == 1 || op == 3);
      ri.wr   = (op >= 2);
      ri.size = 2'($urandom_range(0, 3));
      ri.uns  = 1'($urandom());
      ri.rw   = 1'($urandom());
      ri.dest = 5'($urandom());
      rd_delay = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, TO + 1);
      rr = $urandom();
      run_instr(ri, rd_delay, rr, model(ri, rd_delay, rr), $sformatf("r%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
